// File: rtl/led_pwm_fader.sv
// LED PWM dimmer with steady, blink and breathe modes behind a 4-register
// Avalon-MM slave; the brightness level only changes at PWM period boundaries.
module led_pwm_fader #(
  parameter int unsigned PWM_DIV = 195
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  led_pattern,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led_out
);

  typedef enum logic {
    RISE = 1'b0,
    FALL = 1'b1
  } breathe_e;

  localparam logic [15:0] LP_DIV_M1 = 16'(PWM_DIV - 1);

  logic [7:0]  r_duty;
  logic [1:0]  r_mode;
  logic [7:0]  r_blink_per;
  logic [15:0] r_pcnt;
  logic [7:0]  r_pwm_cnt;
  logic [7:0]  r_bcnt;
  logic [7:0]  r_ramp;
  logic [7:0]  r_lvl;
  logic        r_blink_on;
  breathe_e    r_state;
  logic [7:0]  r_led_out;

  logic        w_wr;
  logic        w_wr_mode;
  logic        w_tick;
  logic        w_period_end;
  logic [7:0]  w_bper_m1;
  logic        w_blink_wrap;
  logic        w_blink_nx;
  logic [7:0]  w_ramp_inc;
  logic [7:0]  w_ramp_dec;
  logic        w_on;
  logic        w_unused;

  assign w_wr         = chipselect && !write_n;
  assign w_wr_mode    = w_wr && (address == 2'd1);
  assign w_tick       = (r_pcnt == LP_DIV_M1);
  assign w_period_end = w_tick && (r_pwm_cnt == 8'hFF);

  // blink_per of 0 is folded onto 1 so the toggle never stalls
  assign w_bper_m1    = (r_blink_per == 8'd0) ? 8'd0
                                              : r_blink_per - 8'd1;
  assign w_blink_wrap = (r_bcnt >= w_bper_m1);
  assign w_blink_nx   = w_blink_wrap ? ~r_blink_on : r_blink_on;

  assign w_ramp_inc   = r_ramp + 8'd1;
  assign w_ramp_dec   = r_ramp - 8'd1;

  assign w_on         = (r_lvl == 8'hFF) || (r_pwm_cnt < r_lvl);
  assign w_unused     = &{1'b0, writedata[31:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_duty      <= 8'hFF;
      r_mode      <= 2'd0;
      r_blink_per <= 8'd64;
    end else if (w_wr) begin
      unique case (address)
        2'd0:    r_duty      <= writedata[7:0];
        2'd1:    r_mode      <= writedata[1:0];
        2'd2:    r_blink_per <= writedata[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_wr_mode) begin
      r_pcnt    <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + 16'd1;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
    end
  end

  // a mode write restarts the effect even if it lands on a period end
  always_ff @(posedge clk) begin
    if (reset || w_wr_mode) begin
      r_bcnt     <= '0;
      r_ramp     <= '0;
      r_lvl      <= '0;
      r_blink_on <= 1'b1;
      r_state    <= RISE;
    end else if (w_period_end) begin
      unique case (r_mode)
        2'd1: begin
          r_bcnt     <= w_blink_wrap ? 8'd0 : r_bcnt + 8'd1;
          r_blink_on <= w_blink_nx;
          r_lvl      <= w_blink_nx ? r_duty : 8'd0;
        end
        2'd2: begin
          if (r_ramp > r_duty) begin
            r_ramp  <= r_duty;
            r_lvl   <= r_duty;
            r_state <= FALL;
          end else if (r_state == RISE) begin
            if (r_ramp < r_duty) begin
              r_ramp <= w_ramp_inc;
              r_lvl  <= w_ramp_inc;
              if (w_ramp_inc == r_duty) begin
                r_state <= FALL;
              end
            end else begin
              r_lvl   <= r_ramp;
              r_state <= FALL;
            end
          end else begin
            if (r_ramp != 8'd0) begin
              r_ramp <= w_ramp_dec;
              r_lvl  <= w_ramp_dec;
              if (w_ramp_dec == 8'd0) begin
                r_state <= RISE;
              end
            end else begin
              r_lvl   <= 8'd0;
              r_state <= RISE;
            end
          end
        end
        default: r_lvl <= r_duty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led_out <= '0;
    end else begin
      r_led_out <= led_pattern & {8{w_on}};
    end
  end

  assign led_out = r_led_out;

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata[7:0] = r_duty;
      2'd1: readdata[1:0] = r_mode;
      2'd2: readdata[7:0] = r_blink_per;
      2'd3: readdata[9:0] = {r_state == FALL,
                             r_blink_on, r_lvl};
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with PWM_DIV=2 (512-clock PWM period).
module tb_led_pwm_fader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  led_pattern = 8'hA5;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  led_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_pwm_fader #(.PWM_DIV(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .led_pattern (led_pattern),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .led_out     (led_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic chk_st(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    rd(2'd3, d);
    chk(tag, d, exp);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic count(input int n, input logic [7:0] pat,
                       output int on, output int off);
    on  = 0;
    off = 0;
    repeat (n) begin
      @(negedge clk);
      if (led_out == pat) on++;
      else if (led_out == 8'h00) off++;
    end
  endtask

  logic [31:0] bl_st [7] = '{32'h100, 32'h1FF, 32'h000, 32'h000,
                             32'h1FF, 32'h1FF, 32'h000};
  logic [7:0]  bl_led [7] = '{8'h00, 8'h3C, 8'h00, 8'h00,
                              8'h3C, 8'h3C, 8'h00};
  logic [31:0] br_st [9] = '{32'h100, 32'h101, 32'h102, 32'h303,
                             32'h302, 32'h301, 32'h100, 32'h101,
                             32'h102};

  initial begin
    logic [31:0] d;
    int on, off;

    // reset state
    do_reset();
    rd(2'd0, d); chk("rst_duty", d, 32'hFF);
    rd(2'd1, d); chk("rst_mode", d, 32'h0);
    rd(2'd2, d); chk("rst_bper", d, 32'd64);
    chk_st("rst_status", 32'h100);
    chk("rst_led", {24'h0, led_out}, 32'h0);

    // steady dimming, duty 0x40
    wr(2'd0, 32'h40);
    count(500, 8'hA5, on, off);
    chk("p0_dark", off, 32'd500);
    step(10);
    chk("pe_edge", {24'h0, led_out}, 32'h00);
    step(1);
    chk("on_start", {24'h0, led_out}, 32'hA5);
    step(127);
    chk("on_last", {24'h0, led_out}, 32'hA5);
    step(1);
    chk("off_first", {24'h0, led_out}, 32'h00);
    chk_st("dim_status", 32'h140);
    count(512, 8'hA5, on, off);
    chk("dim_on", on, 32'd128);
    chk("dim_off", off, 32'd384);

    // duty extremes
    wr(2'd0, 32'h00);
    step(600);
    count(512, 8'hA5, on, off);
    chk("d0_off", off, 32'd512);
    wr(2'd0, 32'hFF);
    step(600);
    led_pattern = 8'h3C;
    #1;
    chk("pat_old", {24'h0, led_out}, 32'hA5);
    @(negedge clk);
    chk("pat_new", {24'h0, led_out}, 32'h3C);
    count(512, 8'h3C, on, off);
    chk("dff_on", on, 32'd512);

    // blink, 2 periods on / 2 off
    wr(2'd2, 32'd2);
    wr(2'd1, 32'd1);
    step(256);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("blink_st%0d", k), 32'(0), 32'(0) | 32'(0));
      n_vec--;
      chk_st($sformatf("blink_st%0d", k), bl_st[k]);
      chk($sformatf("blink_led%0d", k), {24'h0, led_out},
          {24'h0, bl_led[k]});
      step(512);
    end

    // breathe, duty 3
    wr(2'd0, 32'd3);
    wr(2'd1, 32'd2);
    step(256);
    for (int k = 0; k < 9; k++) begin
      chk_st($sformatf("breathe%0d", k), br_st[k]);
      step(512);
    end

    // duty written below ramp
    wr(2'd0, 32'd10);
    wr(2'd1, 32'd2);
    step(256);
    for (int k = 1; k <= 6; k++) begin
      step(512);
      chk_st($sformatf("ramp%0d", k), 32'h100 + 32'(k));
    end
    wr(2'd0, 32'd2);
    step(510);
    chk_st("clamp_fall", 32'h302);
    step(512);
    chk_st("clamp_next", 32'h301);

    // reset mid-breathe
    wr(2'd2, 32'd9);
    do_reset();
    rd(2'd0, d); chk("rst2_duty", d, 32'hFF);
    rd(2'd1, d); chk("rst2_mode", d, 32'h0);
    rd(2'd2, d); chk("rst2_bper", d, 32'd64);
    chk_st("rst2_status", 32'h100);
    chk("rst2_led", {24'h0, led_out}, 32'h0);
    step(505);
    chk_st("rst2_p0", 32'h100);
    step(10);
    chk_st("rst2_p1", 32'h1FF);
    chk("rst2_led_p1", {24'h0, led_out}, 32'h3C);

    // mode write exactly on a period end
    do_reset();
    step(510);
    wr(2'd1, 32'd2);
    chk_st("mw_pe_lvl", 32'h100);
    rd(2'd1, d); chk("mw_mode", d, 32'd2);
    step(511);
    chk_st("mw_before", 32'h100);
    step(1);
    chk_st("mw_after", 32'h101);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 SHALL have parameter PWM_DIV, default 195, meaning clocks per PWM tick (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning a synchronous, active-high reset.
REQ-004 SHALL have port led_pattern, input, 8, meaning the LED on/off pattern taken directly from the LEDs PIO out_port.
REQ-005 SHALL have port address, input, 2, meaning the Avalon-MM slave register select.
REQ-006 SHALL have port chipselect, input, 1, meaning the Avalon-MM slave select.
REQ-007 SHALL have port write_n, input, 1, meaning the active-low Avalon-MM write strobe.
REQ-008 SHALL have port writedata, input, 32, meaning the Avalon-MM write data.
REQ-009 SHALL have port readdata, output, 32, meaning combinational read data; unused bits are 0.
REQ-010 SHALL have port led_out, output, 8, meaning the registered, dimmed LED drive to the pins.

Function
REQ-011 SHALL decode a write as chipselect=1 && write_n=0, with zero wait states.
REQ-012 SHALL implement the following registers.
- addr 0: duty[7:0], R/W, reset 0xFF.
- addr 1: mode[1:0], R/W, reset 0. Encodings: 0=steady, 1=blink, 2=breathe, 3=treated as steady.
- addr 2: blink_per[7:0], R/W, reset 64, in PWM periods.
- addr 3: status, read-only. Bits [7:0] = lvl, bit 8 = blink_on, bit 9 = fall; writes to addr 3 are ignored.
REQ-013 SHALL clock a prescaler pcnt from 0 to PWM_DIV-1 and wrap it to 0; tick=1 on the cycle pcnt==PWM_DIV-1.
REQ-014 SHALL increment the 8-bit pwm_cnt on each tick, wrapping 255->0; period_end = tick && pwm_cnt==255.
REQ-015 SHALL update lvl only on period_end, so that no duty change appears mid-period.
- steady: lvl = duty.
- blink: lvl = blink_on ? duty : 0.
- breathe: lvl = ramp.
REQ-016 SHALL register led_out[i] = led_pattern[i] && (lvl==255 || pwm_cnt < lvl), one clock after its inputs.
REQ-017 SHALL give the following boundary results: lvl=0 -> led_out=0 constantly; lvl=255 -> led_out=led_pattern constantly.
REQ-018 SHALL run the blink logic as follows.
- On each period_end in blink mode, bcnt increments.
- When bcnt reaches max(blink_per,1)-1, blink_on toggles and bcnt returns to 0.
- blink_per=0 therefore behaves as blink_per=1.
REQ-019 SHALL run the breathe FSM with states RISE and FALL, advancing only on period_end.
- RISE: ramp increments while ramp<duty; when ramp>=duty, ramp is set to duty and the state moves to FALL.
- FALL: ramp decrements while ramp>0; when ramp==0, the state moves to RISE.
- duty=0: ramp stays 0 and the state alternates between RISE and FALL each period.
REQ-020 SHALL make the FSM move to FALL on the next period_end, with ramp set to duty, when duty is written below the current ramp.
REQ-021 SHALL, on a write to mode, clear bcnt, ramp and pcnt/pwm_cnt, set blink_on=1, set the FSM to RISE and set lvl to 0 on the following cycle.
REQ-022 SHALL give precedence to the mode write clears when a mode write coincides with period_end.
REQ-023 SHALL make led_pattern changes appear on led_out one clock later, with no period alignment.

Reset
REQ-024 SHALL, while reset=1 at a clock edge, set duty=0xFF, mode=0, blink_per=64, pcnt=0, pwm_cnt=0, bcnt=0, ramp=0, lvl=0, blink_on=1, FSM=RISE and led_out=0.
REQ-025 SHALL abort any in-progress period, blink or ramp when reset is asserted mid-operation, with no residual state.
REQ-026 SHALL make lvl take duty at the first period_end after reset is released.

Verification (PWM_DIV=2)
REQ-027 SHALL cover steady dimming: reset, led_pattern=0xA5, duty=0x40 -> from the 2nd period on, led_out=0xA5 for 128 clk and 0x00 for 384 clk of each 512-clk period.
REQ-028 SHALL cover the duty extremes: duty=0x00 -> led_out=0 always; duty=0xFF -> led_out==led_pattern always, with 1-clk latency after a pattern change.
REQ-029 SHALL cover blink: mode=1, blink_per=2, duty=0xFF -> led_out alternates 2 periods on and 2 periods off (2048 clk cycle); status bit 8 toggles in step.
REQ-030 SHALL cover breathe: mode=2, duty=3 -> lvl sequence per period is 0,1,2,3,2,1,0,1...; status bit 9 is set while falling.
REQ-031 SHALL cover a duty write below ramp: breathe with duty=10, write duty=2 when ramp=6 -> next period lvl=2 and FSM=FALL.
REQ-032 SHALL cover reset and mode write: reset mid-breathe -> all registers return to their REQ-024 values and readdata at addr 0 = 0xFF; a mode write on a period_end cycle -> ramp=0 and pwm_cnt=0 on the next cycle.
